regwb_queue: RTL and testbench

Register-file write-back queue: the write-side initiator for the 32-entry register file. It accepts completed results over a valid/ready handshake, buffers them in order, and drives the register file's `writereg`/`rd`/`writedata` port one entry per granted cycle. It also forwards queued data to the decode stage's two read addresses, so reads never see stale values while writes are still pending.

---
 rtl/regwb_queue.sv | 96 +++++++++
 tb/tb_regwb_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regwb_queue.sv
// In-order register-file write-back queue with youngest-match read forwarding.
// An entry is on the write port the cycle after it is pushed into an empty queue; in_ready drops only when all DEPTH slots are held.
module regwb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       wb_en,
  output logic                       writereg,
  output logic [ADDR_W-1:0]          rd,
  output logic [DATA_W-1:0]          writedata,
  input  logic [ADDR_W-1:0]          rs1,
  input  logic [ADDR_W-1:0]          rs2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd1_data,
  output logic [DATA_W-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   idx;
  logic            push;
  logic            enq;
  logic            pop;

  assign empty     = (count == '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  // x0 completes the handshake but never occupies a slot
  assign enq       = push & (in_rd != '0);
  assign writereg  = !empty & wb_en;
  assign pop       = writereg;
  assign rd        = empty ? '0 : mem[head].rd;
  assign writedata = empty ? '0 : mem[head].data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= '{rd: in_rd, data: in_data};
        tail      <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (rs1 != '0 && mem[idx].rd == rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem[idx].data;
        end
        if (rs2 != '0 && mem[idx].rd == rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regwb_queue.sv
// Scoreboard bench for regwb_queue: stimulus pushes expected writes, a negedge monitor retires them.
module tb_regwb_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        wb_en = 1'b0;
  logic        writereg;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [2:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb [$];

  always #5 clock = ~clock;

  regwb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_en(wb_en), .writereg(writereg), .rd(rd), .writedata(writedata),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the coming edge; acc marks a push known to be accepted
  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic w, input bit acc);
    in_valid = v;
    in_rd    = r;
    in_data  = d;
    wb_en    = w;
    if (acc && v && r != 5'd0) sb.push_back({r, d});
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every write strobe must match the oldest expected entry
  always @(negedge clock) begin
    if (reset && writereg) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd=%0d data=%0h with nothing pending", rd, writedata);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_rd", 64'(rd), 64'(e[36:32]));
        chk("wb_data", 64'(writedata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_writereg", 64'(writereg), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_writedata", 64'(writedata), 64'd0);
    chk("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single write
    drive(1, 5'd3, 32'hDEADBEEF, 1, 1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("single_writereg", 64'(writereg), 64'd1);
    chk("single_rd", 64'(rd), 64'd3);
    chk("single_data", 64'(writedata), 64'hDEADBEEF);
    chk("single_count1", 64'(count), 64'd1);
    tick();
    chk("single_count0", 64'(count), 64'd0);
    chk("single_empty", 64'(empty), 64'd1);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(10 + i), 32'(32'hA0 + i), 0, 1);
      tick();
    end
    drive(1, 5'd20, 32'hBAD, 0, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_writereg", 64'(writereg), 64'd0);
    tick();
    chk("full_refused", 64'(count), 64'd4);
    drive(1, 5'd21, 32'hBAD, 1, 0);
    tick();
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 1, 0);
    tick(); tick(); tick();
    chk("drain_empty", 64'(empty), 64'd1);

    // Forwarding priority
    rs1 = 5'd7;
    rs2 = 5'd8;
    drive(1, 5'd7, 32'h11, 0, 1);
    chk("fwd_stale_slot", 64'(fwd1_hit), 64'd0);
    tick();
    drive(1, 5'd7, 32'h22, 0, 1);
    chk("fwd_push_not_seen", 64'(fwd1_data), 64'h11);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("fwd1_hit", 64'(fwd1_hit), 64'd1);
    chk("fwd1_youngest", 64'(fwd1_data), 64'h22);
    chk("fwd2_miss_hit", 64'(fwd2_hit), 64'd0);
    chk("fwd2_miss_data", 64'(fwd2_data), 64'd0);
    rs2 = 5'd7;
    #1;
    chk("fwd2_youngest", 64'(fwd2_data), 64'h22);
    drive(0, 0, 0, 1, 0);
    chk("fwd_during_write", 64'(fwd1_data), 64'h22);
    tick();
    chk("fwd_head_write_hit", 64'(fwd1_hit), 64'd1);
    chk("fwd_head_write_data", 64'(fwd1_data), 64'h22);
    tick();
    chk("fwd_after_drain", 64'(fwd1_hit), 64'd0);
    rs2 = 5'd0;

    // x0 handling
    rs1 = 5'd0;
    drive(1, 5'd0, 32'hFFFF, 1, 1);
    chk("x0_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_writereg", 64'(writereg), 64'd0);
    chk("x0_fwd", 64'(fwd1_hit), 64'd0);

    // Wrap with simultaneous push/pop
    for (int i = 1; i <= 10; i++) begin
      drive(1, 5'(i), 32'(i * 32'h100), 1, 1);
      if (i > 1) chk("stream_count", 64'(count), 64'd1);
      if (i > 1) chk("stream_writereg", 64'(writereg), 64'd1);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    tick();
    chk("stream_done", 64'(count), 64'd0);

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(24 + i), 32'(32'h500 + i), 0, 1);
      tick();
    end
    chk("pre_reset_count", 64'(count), 64'd3);
    drive(0, 0, 0, 1, 0);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("arst_writereg", 64'(writereg), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_reset_count", 64'(count), 64'd0);
    drive(1, 5'd9, 32'h99, 1, 1);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    chk("post_reset_empty", 64'(empty), 64'd1);
    tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
